package_feeder: RTL and testbench



---
 rtl/package_feeder.sv | 219 +++++++++++++++++++++
 tb/tb_package_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/package_feeder.sv
// Scale-bus feeder: queues {weight, hold} requests and plays each as a plateau then a zero gap.
// Latency: request accepted at edge k into an idle feeder drives weight after edge k+1.
// Backpressure: in_ready drops when the FIFO is full, or while reset is asserted. Optional FEEDER_CLASSIFY_EN adds exp_grp.

module package_feeder_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat,
    output logic [3:0]   o_level,
    output logic         o_full,
    output logic         o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (r_count == 4'(DEPTH));
    assign o_empty = (r_count == 4'd0);
    assign o_level = r_count;
    assign o_dat   = r_mem[r_rd_ptr];
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module package_feeder #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_weight,
    input  logic [3:0]  in_hold,
    output logic [11:0] weight,
    output logic        busy,
    output logic [3:0]  level,
    output logic        pkt_done,
    output logic [7:0]  pkt_count,
    output logic        zero_drop
`ifdef FEEDER_CLASSIFY_EN
    ,
    output logic [2:0]  exp_grp
`endif
);
    typedef struct packed {
        logic [11:0] wt;
        logic [3:0]  hold;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int         GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam logic [3:0] GAP_LAST = 4'(GAP_EFF - 1);

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_weight;
    logic [3:0]  r_hold_cnt;
    logic [3:0]  r_gap_cnt;
    logic        r_pkt_done;
    logic [7:0]  r_pkt_count;
    logic        r_zero_drop;

    logic        w_xfer;
    logic        w_push;
    logic        w_zero;
    logic        w_pop;
    logic        w_finish;
    logic        w_full;
    logic        w_empty;
    logic [3:0]  w_level;
    entry_t      w_in_ent;
    entry_t      w_head;

    assign in_ready = !reset && !w_full;
    assign w_xfer   = in_valid && in_ready;
    // Zero-weight requests complete the handshake but never reach the FIFO.
    assign w_push   = w_xfer && (in_weight != 12'd0);
    assign w_zero   = w_xfer && (in_weight == 12'd0);
    assign w_in_ent = '{wt: in_weight, hold: in_hold};

    package_feeder_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (w_in_ent),
        .o_dat   (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (!w_empty) w_next = S_LOAD;
            S_LOAD: if (r_hold_cnt == 4'd0) w_next = S_GAP;
            S_GAP:  if (r_gap_cnt == 4'd0) w_next = w_empty ? S_IDLE : S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop    = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: w_pop    = !w_empty;
            S_LOAD: w_finish = (r_hold_cnt == 4'd0);
            S_GAP:  w_pop    = (r_gap_cnt == 4'd0) && !w_empty;
            default: ;
        endcase
    end

`ifdef FEEDER_CLASSIFY_EN
    logic [2:0] r_exp_grp;

    function automatic logic [2:0] classify(input logic [11:0] w);
        if (w == 12'd0)        return 3'd0;
        else if (w <= 12'd250)  return 3'd1;
        else if (w <= 12'd500)  return 3'd2;
        else if (w <= 12'd750)  return 3'd3;
        else if (w <= 12'd1500) return 3'd4;
        else if (w <= 12'd2000) return 3'd5;
        else                    return 3'd6;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_exp_grp <= 3'd0;
        else if (w_finish) r_exp_grp <= classify(r_weight);
    end

    assign exp_grp = r_exp_grp;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_weight    <= '0;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_pkt_done  <= 1'b0;
            r_pkt_count <= '0;
            r_zero_drop <= 1'b0;
        end else begin
            r_pkt_done  <= w_finish;
            r_zero_drop <= w_zero;
            if (w_pop) begin
                // Stored hold 0 means a one-cycle plateau.
                r_weight   <= w_head.wt;
                r_hold_cnt <= (w_head.hold == 4'd0) ? 4'd0 : w_head.hold - 4'd1;
            end else if (w_finish) begin
                r_weight    <= '0;
                r_gap_cnt   <= GAP_LAST;
                r_pkt_count <= r_pkt_count + 8'd1;
            end else begin
                if (r_state == S_LOAD && r_hold_cnt != 4'd0) r_hold_cnt <= r_hold_cnt - 4'd1;
                if (r_state == S_GAP && r_gap_cnt != 4'd0)   r_gap_cnt  <= r_gap_cnt - 4'd1;
            end
        end
    end

    assign weight    = r_weight;
    assign busy      = !w_empty || (r_state != S_IDLE);
    assign level     = w_level;
    assign pkt_done  = r_pkt_done;
    assign pkt_count = r_pkt_count;
    assign zero_drop = r_zero_drop;
endmodule

// File: tb/tb_package_feeder.sv
// Bench for package_feeder: request table plus a plateau scoreboard watching the weight bus.
module tb_package_feeder;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_weight;
    logic [3:0]  in_hold;
    logic [11:0] weight;
    logic        busy;
    logic [3:0]  level;
    logic        pkt_done;
    logic [7:0]  pkt_count;
    logic        zero_drop;
`ifdef FEEDER_CLASSIFY_EN
    logic [2:0]  exp_grp;
`endif

    package_feeder #(.DEPTH(4), .GAP_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_hold   (in_hold),
        .weight    (weight),
        .busy      (busy),
        .level     (level),
        .pkt_done  (pkt_done),
        .pkt_count (pkt_count),
        .zero_drop (zero_drop)
`ifdef FEEDER_CLASSIFY_EN
        ,
        .exp_grp   (exp_grp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] w;
        logic [3:0]  hold;
        int          exp_len;
        int          exp_grp;
    } vec_t;

    typedef struct {
        int w;
        int len;
        int grp;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    exp_t m_e;

    int checks = 0;
    int errors = 0;

    bit mon_en = 1'b0;
    bit tight  = 1'b0;
    bit m_in_pl;
    bit m_have_prev;
    int m_len;
    int m_w;
    int m_zero_run;
    int exp_count;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_clear();
        m_in_pl     = 1'b0;
        m_have_prev = 1'b0;
        m_len       = 0;
        m_w         = 0;
        m_zero_run  = 0;
        exp_count   = 0;
    endtask

    // Scoreboard: every plateau on the bus must match the oldest outstanding request.
    always @(negedge clk) begin
        if (mon_en) begin
            if (weight != 12'd0) begin
                if (!m_in_pl) begin
                    if (m_have_prev) begin
                        chk("gap_min", int'(m_zero_run >= 2), 1);
                        if (tight) chk("gap_exact", m_zero_run, 2);
                    end
                    m_in_pl = 1'b1;
                    m_len   = 1;
                    m_w     = int'(weight);
                end else begin
                    chk("plateau_stable", int'(weight), m_w);
                    m_len++;
                end
            end else if (m_in_pl) begin
                m_in_pl     = 1'b0;
                m_have_prev = 1'b1;
                m_zero_run  = 1;
                exp_count++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_plateau", m_w, 0);
                end else begin
                    m_e = sb_q.pop_front();
                    chk("plateau_weight", m_w, m_e.w);
                    chk("plateau_len", m_len, m_e.len);
`ifdef FEEDER_CLASSIFY_EN
                    chk("exp_grp", int'(exp_grp), m_e.grp);
`endif
                end
                chk("pkt_done_at_end", int'(pkt_done), 1);
                chk("pkt_count_at_end", int'(pkt_count), exp_count % 256);
            end else begin
                m_zero_run++;
                chk("pkt_done_idle", int'(pkt_done), 0);
            end
        end
    end

    task automatic push(input logic [11:0] w, input logic [3:0] h, input int len, input int grp);
        int t;
        t = 0;
        in_valid  = 1'b1;
        in_weight = w;
        in_hold   = h;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            @(posedge clk);
            if (w != 12'd0) sb_q.push_back('{int'(w), len, grp});
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int t;
        t = 0;
        while (busy && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", int'(busy), 0);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_weight = '0;
        in_hold   = '0;
        mon_clear();

        vecs[0] = '{12'd300,  4'd3,  3,  2};
        vecs[1] = '{12'd1200, 4'd15, 15, 4};
        vecs[2] = '{12'd50,   4'd1,  1,  1};
        vecs[3] = '{12'd600,  4'd2,  2,  3};
        vecs[4] = '{12'd1800, 4'd0,  1,  5};
        vecs[5] = '{12'd2500, 4'd4,  4,  6};
        vecs[6] = '{12'd4095, 4'd0,  1,  6};

        repeat (3) @(negedge clk);
        chk("rst_weight", int'(weight), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_pkt_count", int'(pkt_count), 0);
        chk("rst_pkt_done", int'(pkt_done), 0);
        chk("rst_zero_drop", int'(zero_drop), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
`ifdef FEEDER_CLASSIFY_EN
        chk("rst_exp_grp", int'(exp_grp), 0);
`endif
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", int'(in_ready), 1);
        mon_en = 1'b1;

        // Single package: check first-output latency by hand, shape via scoreboard.
        push(vecs[0].w, vecs[0].hold, vecs[0].exp_len, vecs[0].exp_grp);
        chk("lat_edge_k", int'(weight), 0);
        @(negedge clk);
        chk("lat_edge_k1", int'(weight), 300);
        wait_idle(200);
        chk("count_after_first", int'(pkt_count), 1);

        // Burst behind a long plateau fills the FIFO; queued packages leave with exact gaps.
        for (int i = 1; i <= 5; i++) push(vecs[i].w, vecs[i].hold, vecs[i].exp_len, vecs[i].exp_grp);
        chk("burst_level_full", int'(level), 4);
        chk("burst_in_ready_low", int'(in_ready), 0);
        tight = 1'b1;
        wait_idle(500);
        tight = 1'b0;
        chk("count_after_burst", int'(pkt_count), 6);

        // Zero-weight request is swallowed.
        push(12'd0, 4'd2, 0, 0);
        chk("zero_drop_pulse", int'(zero_drop), 1);
        chk("zero_level", int'(level), 0);
        chk("zero_weight", int'(weight), 0);
        @(negedge clk);
        chk("zero_drop_clear", int'(zero_drop), 0);
        chk("zero_count", int'(pkt_count), 6);
        chk("zero_busy", int'(busy), 0);

        push(vecs[6].w, vecs[6].hold, vecs[6].exp_len, vecs[6].exp_grp);
        wait_idle(200);
        chk("count_after_max", int'(pkt_count), 7);

        // Reset in the middle of a plateau with two packages still queued.
        mon_en = 1'b0;
        push(12'd1000, 4'd10, 10, 4);
        push(12'd600, 4'd1, 1, 3);
        push(12'd700, 4'd1, 1, 3);
        repeat (2) @(negedge clk);
        chk("pre_reset_weight", int'(weight), 1000);
        chk("pre_reset_level", int'(level), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_weight", int'(weight), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_count", int'(pkt_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        repeat (20) @(negedge clk);
        chk("post_rst_weight", int'(weight), 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_count", int'(pkt_count), 0);
        chk("post_rst_done", int'(pkt_done), 0);
        mon_clear();
        mon_en = 1'b1;

        // 256 packages wrap the counter back to zero.
        for (int i = 0; i < 256; i++) push(12'd100, 4'd0, 1, 1);
        wait_idle(2000);
        chk("wrap_count", int'(pkt_count), 0);
        chk("wrap_seen", exp_count, 256);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
